// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared types and sizes for the issue controller
package issue_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam int NREG = 32;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// reg_scoreboard: per-register pending-write vector with hazard lookup and writeback bypass
module reg_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int N = NREG,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             wb_vld,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             fl_en,
  input  logic [REG_W-1:0] fl_idx,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             rs1_en,
  input  logic             rs2_en,
  input  logic             rd_en,
  output logic             raw,
  output logic             waw,
  output logic [N-1:0]     pend
);
  logic [N-1:0] pend_q, pend_d;
  function automatic logic busy(input logic [REG_W-1:0] r);
    return pend_q[r] & ~(BYPASS & wb_vld & (wb_rd == r));
  endfunction
  assign raw  = (rs1_en & busy(rs1)) | (rs2_en & busy(rs2));
  assign waw  = rd_en & (rd != '0) & busy(rd);
  assign pend = pend_q;
  // set is applied last so it wins over a same-index clear
  always_comb begin
    pend_d = pend_q;
    if (wb_vld) pend_d[wb_rd] = 1'b0;
    if (fl_en) pend_d[fl_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else pend_q <= pend_d;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: hazard-checked issue stage with MUL/DIV serialisation and a one-entry issue register
module issue_scoreboard #(
  parameter int NREG = issue_scoreboard_pkg::NREG,
  parameter bit BYPASS_WB = 1'b1,
  parameter int PERF_W = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                dec_vld,
  output logic                                dec_rdy,
  input  logic [issue_scoreboard_pkg::REG_W-1:0] dec_rd,
  input  logic [issue_scoreboard_pkg::REG_W-1:0] dec_rs1,
  input  logic [issue_scoreboard_pkg::REG_W-1:0] dec_rs2,
  input  logic                                dec_rd_en,
  input  logic                                dec_rs1_en,
  input  logic                                dec_rs2_en,
  input  logic                                dec_md,
  input  logic [63:0]                         dec_pc,
  output logic                                iss_vld,
  input  logic                                iss_rdy,
  output logic [issue_scoreboard_pkg::REG_W-1:0] iss_rd,
  output logic                                iss_rd_en,
  output logic                                iss_md,
  output logic [63:0]                         iss_pc,
  input  logic                                wb_vld,
  input  logic [issue_scoreboard_pkg::REG_W-1:0] wb_rd,
  input  logic                                md_done,
  input  logic                                flush,
  output logic [NREG-1:0]                     pend,
  output logic [PERF_W-1:0]                   stall_cnt
);
  import issue_scoreboard_pkg::*;
  md_state_e        state_q, state_d;
  logic             raw, waw, mdblk, fire, md_kill;
  logic             iss_vld_q, iss_rd_en_q, iss_md_q;
  logic [REG_W-1:0] iss_rd_q;
  logic [63:0]      iss_pc_q;
  logic [PERF_W-1:0] stall_q;
  assign dec_rdy = ~raw & ~waw & ~mdblk & ~flush & (~iss_vld_q | iss_rdy);
  assign fire    = dec_vld & dec_rdy;
  assign md_kill = flush & iss_vld_q & iss_md_q;
  reg_scoreboard #(.N(NREG), .BYPASS(BYPASS_WB)) u_sb (
    .clk(clk), .rst_n(rst_n),
    .set_en(fire & dec_rd_en & (dec_rd != '0)), .set_idx(dec_rd),
    .wb_vld(wb_vld), .wb_rd(wb_rd),
    .fl_en(flush & iss_vld_q & iss_rd_en_q & (iss_rd_q != '0)), .fl_idx(iss_rd_q),
    .rs1(dec_rs1), .rs2(dec_rs2), .rd(dec_rd),
    .rs1_en(dec_rs1_en), .rs2_en(dec_rs2_en), .rd_en(dec_rd_en),
    .raw(raw), .waw(waw), .pend(pend)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= MD_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == MD_IDLE) ? ((fire & dec_md) ? MD_BUSY : MD_IDLE)
                                   : ((md_done | md_kill) ? MD_IDLE : MD_BUSY);
  always_comb mdblk = dec_md & (state_q != MD_IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iss_vld_q   <= 1'b0;
      iss_rd_q    <= '0;
      iss_rd_en_q <= 1'b0;
      iss_md_q    <= 1'b0;
      iss_pc_q    <= '0;
      stall_q     <= '0;
    end else begin
      if (flush) iss_vld_q <= 1'b0;
      else if (fire) iss_vld_q <= 1'b1;
      else if (iss_rdy) iss_vld_q <= 1'b0;
      if (fire) begin
        iss_rd_q    <= dec_rd;
        iss_rd_en_q <= dec_rd_en;
        iss_md_q    <= dec_md;
        iss_pc_q    <= dec_pc;
      end
      if (dec_vld & ~dec_rdy & ~&stall_q) stall_q <= stall_q + PERF_W'(1);
    end
  assign iss_vld   = iss_vld_q;
  assign iss_rd    = iss_rd_q;
  assign iss_rd_en = iss_rd_en_q;
  assign iss_md    = iss_md_q;
  assign iss_pc    = iss_pc_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios then random traffic against a rule-level reference model
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        dec_vld, dec_rdy, dec_rd_en, dec_rs1_en, dec_rs2_en, dec_md;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, iss_rd, wb_rd;
  logic [63:0] dec_pc, iss_pc;
  logic        iss_vld, iss_rdy, iss_rd_en, iss_md, wb_vld, md_done, flush;
  logic [31:0] pend, stall_cnt;
  int passed = 0, total = 0;
  bit pend_m[32];
  bit ivld_m, ien_m, imd_m, busy_m;
  logic [4:0]  ird_m;
  logic [63:0] ipc_m, pc_hold;
  int unsigned stall_m;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd_en(dec_rd_en), .dec_rs1_en(dec_rs1_en),
    .dec_rs2_en(dec_rs2_en), .dec_md(dec_md), .dec_pc(dec_pc), .iss_vld(iss_vld),
    .iss_rdy(iss_rdy), .iss_rd(iss_rd), .iss_rd_en(iss_rd_en), .iss_md(iss_md),
    .iss_pc(iss_pc), .wb_vld(wb_vld), .wb_rd(wb_rd), .md_done(md_done), .flush(flush),
    .pend(pend), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit hz(input logic [4:0] r);
    return pend_m[r] && !(wb_vld && wb_rd == r);
  endfunction

  function automatic bit rdy_m();
    bit raw = (dec_rs1_en && hz(dec_rs1)) || (dec_rs2_en && hz(dec_rs2));
    bit waw = dec_rd_en && dec_rd != 0 && hz(dec_rd);
    return !raw && !waw && !(dec_md && busy_m) && !flush && (!ivld_m || iss_rdy);
  endfunction

  function automatic logic [31:0] pendv();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend_m[i];
    return v;
  endfunction

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    {ivld_m, ien_m, imd_m, busy_m} = '0;
    ird_m = '0; ipc_m = '0; stall_m = 0;
  endtask

  task automatic idle();
    dec_vld = 0; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
    {dec_rd_en, dec_rs1_en, dec_rs2_en, dec_md} = '0;
    dec_pc = 0; iss_rdy = 1; wb_vld = 0; wb_rd = 0; md_done = 0; flush = 0;
  endtask

  task automatic dec(input logic [4:0] rd, rs1, rs2, input bit rd_en, rs1_en, rs2_en, md);
    dec_vld = 1; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_rd_en = rd_en; dec_rs1_en = rs1_en; dec_rs2_en = rs2_en; dec_md = md;
    dec_pc = {$urandom, $urandom};
  endtask

  // compare every output against the model, then advance the model across the next edge
  task automatic cyc();
    bit r, f, nb;
    #1;
    r = rdy_m();
    chk("dec_rdy", dec_rdy, r);
    chk("pend", pend, pendv());
    chk("iss_vld", iss_vld, ivld_m);
    chk("iss_rd", iss_rd, ird_m);
    chk("iss_rd_en", iss_rd_en, ien_m);
    chk("iss_md", iss_md, imd_m);
    chk("iss_pc", iss_pc, ipc_m);
    chk("stall_cnt", stall_cnt, stall_m);
    chk("md_state", dut.state_q, busy_m ? MD_BUSY : MD_IDLE);
    f = dec_vld && r;
    if (dec_vld && !r) stall_m++;
    nb = busy_m ? !(md_done || (flush && ivld_m && imd_m)) : (f && dec_md);
    if (wb_vld) pend_m[wb_rd] = 0;
    if (flush && ivld_m && ien_m && ird_m != 0) pend_m[ird_m] = 0;
    if (f && dec_rd_en && dec_rd != 0) pend_m[dec_rd] = 1;
    if (flush) ivld_m = 0;
    else if (f) begin
      ivld_m = 1; ird_m = dec_rd; ien_m = dec_rd_en; imd_m = dec_md; ipc_m = dec_pc;
    end else if (iss_rdy) ivld_m = 0;
    busy_m = nb;
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    cyc();
    rst_n = 1;
    cyc();
    // T1: RAW on x5 stalls until its writeback, bypass lets it issue in the wb cycle
    dec(5, 0, 0, 1, 1, 0, 0); cyc();
    dec(6, 5, 5, 1, 1, 1, 0);
    repeat (3) cyc();
    wb_vld = 1; wb_rd = 5; cyc();
    idle(); #1 chk("t1_stall", stall_cnt, 3);
    cyc();
    // T2: second MUL/DIV waits for md_done, fires the cycle after
    dec(7, 1, 2, 1, 1, 1, 1); cyc();
    dec(8, 1, 2, 1, 1, 1, 1);
    repeat (3) cyc();
    md_done = 1; cyc();
    md_done = 0; cyc();
    idle(); #1 chk("t2_busy", dut.state_q, MD_BUSY);
    md_done = 1; cyc();
    idle(); cyc();
    // T3: issue register held while EXU is not ready
    iss_rdy = 0; dec(11, 0, 0, 1, 0, 0, 0); pc_hold = dec_pc; cyc();
    dec(12, 0, 0, 1, 0, 0, 0);
    repeat (3) begin
      cyc();
      chk("t3_pc_hold", iss_pc, pc_hold);
    end
    iss_rdy = 1; #1 chk("t3_rdy", dec_rdy, 1);
    cyc();
    idle(); cyc();
    // T4: flush kills the held instruction and its pending write
    iss_rdy = 0; dec(9, 0, 0, 1, 0, 0, 0); cyc();
    idle(); iss_rdy = 0; #1 chk("t4_pend9_set", pend[9], 1);
    flush = 1; cyc();
    idle(); #1;
    chk("t4_pend9", pend[9], 0);
    chk("t4_iss_vld", iss_vld, 0);
    chk("t4_state", dut.state_q, MD_IDLE);
    // T5: same-edge set beats writeback clear; x0 is never pending
    dec(3, 0, 0, 1, 0, 0, 0); wb_vld = 1; wb_rd = 3; cyc();
    idle(); #1 chk("t5_pend3", pend[3], 1);
    dec(0, 0, 0, 1, 0, 0, 0); cyc();
    idle(); #1 chk("t5_pend0", pend[0], 0);
    cyc();
    // T6: asynchronous reset while MUL/DIV is busy
    dec(10, 0, 0, 1, 0, 0, 1); cyc();
    idle(); dec_vld = 1; dec_md = 1; cyc();
    idle();
    #2 rst_n = 0;
    #1;
    chk("t6_pend", pend, 0);
    chk("t6_iss_vld", iss_vld, 0);
    chk("t6_state", dut.state_q, MD_IDLE);
    chk("t6_stall", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc();
    // random traffic over a small register window to provoke hazards
    repeat (600) begin
      dec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0);
      dec_vld = $urandom_range(0, 3) != 0;
      iss_rdy = $urandom_range(0, 3) != 0;
      wb_vld  = $urandom_range(0, 2) == 0;
      wb_rd   = $urandom_range(0, 7);
      md_done = $urandom_range(0, 7) == 0;
      flush   = $urandom_range(0, 15) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
